// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled mid-bit using an OVS-times oversampling baud tick.
// A held-low line after a bad stop bit is reported once, then ignored until it goes high.
module uart_rx #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for a falling edge on rx_s
  // START     | timing to the middle of the start bit to reject glitches
  // DATA      | sampling 8 data bits, LSB first, one per OVS ticks
  // STOP      | sampling the stop bit
  // WAIT_HIGH | bad stop bit seen, waiting for the line to return high
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  localparam logic [3:0] TICK_MID  = 4'(OVS / 2 - 1);
  localparam logic [3:0] TICK_LAST = 4'(OVS - 1);

  logic [2:0] state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       rx_meta;
  logic       rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= 4'd0;
          end
        end
        START: begin
          if (baud_tick) begin
            if (tick_cnt == TICK_MID) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state    <= DATA;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt  <= 4'd0;
              shift_reg <= {rx_s, shift_reg[7:1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= 4'd0;
              if (rx_s) begin
                rx_data <= shift_reg;
                rx_done <= 1'b1;
                state   <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: expected frame outcomes are queued as frames are driven
// and matched against rx_done / frame_err pulses by a monitor.
module tb_uart_rx;

  localparam int OVS      = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OVS * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } ev_t;

  ev_t        sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_hold = 8'h00;
  int         div_cnt  = 0;

  uart_rx #(.OVS(OVS)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  initial baud_tick = 1'b0;
  always @(negedge clk) begin
    div_cnt   = (div_cnt + 1) % TICK_DIV;
    baud_tick = (div_cnt == 0);
  end

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (rx_done === 1'b1 || frame_err === 1'b1) begin
        n_checks++;
        if (rx_done === 1'b1 && frame_err === 1'b1) begin
          n_fail++;
          $display("FAIL pulse_overlap: rx_done=%b frame_err=%b, required never both high", rx_done, frame_err);
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: rx_done=%b frame_err=%b rx_data=%h, required no pulse", rx_done, frame_err, rx_data);
        end else begin
          ev_t ev;
          ev = sb.pop_front();
          if (ev.is_err) begin
            if (frame_err !== 1'b1 || rx_data !== ev.data) begin
              n_fail++;
              $display("FAIL frame_err_event: frame_err=%b rx_data=%h, required frame_err=1 rx_data=%h", frame_err, rx_data, ev.data);
            end
          end else begin
            if (rx_done !== 1'b1 || rx_data !== ev.data) begin
              n_fail++;
              $display("FAIL rx_done_event: rx_done=%b rx_data=%h, required rx_done=1 rx_data=%h", rx_done, rx_data, ev.data);
            end
          end
        end
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bclk);
    rx = 1'b0;
    hold(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(bclk);
    end
    rx = stop_bit;
    hold(bclk);
  endtask

  task automatic push_good(input logic [7:0] d);
    ev_t ev;
    ev.is_err = 1'b0;
    ev.data   = d;
    sb.push_back(ev);
    exp_hold = d;
  endtask

  task automatic push_err();
    ev_t ev;
    ev.is_err = 1'b1;
    ev.data   = exp_hold;
    sb.push_back(ev);
  endtask

  task automatic wait_drain(input string name, input int max_clks);
    int n = 0;
    while (sb.size() != 0 && n < max_clks) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d events outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b0;
    hold(5);
    n_checks++;
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h, required 00", rx_data); end
    n_checks++;
    if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_rx_done: got %b, required 0", rx_done); end
    n_checks++;
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b, required 0", rx_busy); end
    rx = 1'b1;
    hold(3);
    rst = 1'b1;
    exp_hold = 8'h00;
    hold(20);
  endtask

  task automatic test_frame_a5();
    push_good(8'hA5);
    send_frame(8'hA5, 1'b1, BIT_CLKS);
    wait_drain("frame_a5", 4 * BIT_CLKS);
    hold(BIT_CLKS);
    n_checks++;
    if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_rx_data: got %h, required a5", rx_data); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL a5_rx_busy: got %b, required 0", rx_busy); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    hold(8);
    n_checks++;
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b, required 1", rx_busy); end
    hold(3 * TICK_DIV - 8);
    rx = 1'b1;
    hold(100);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b, required 0", rx_busy); end
    n_checks++;
    if (rx_data !== exp_hold) begin n_fail++; $display("FAIL glitch_rx_data: got %h, required %h", rx_data, exp_hold); end
  endtask

  task automatic test_frame_err();
    push_err();
    send_frame(8'h3C, 1'b0, BIT_CLKS);
    hold(40 * TICK_DIV);
    n_checks++;
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_low: got %b, required 1", rx_busy); end
    n_checks++;
    if (rx_data !== exp_hold) begin n_fail++; $display("FAIL break_rx_data: got %h, required %h", rx_data, exp_hold); end
    wait_drain("frame_err", 10);
    rx = 1'b1;
    hold(8);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_high: got %b, required 0", rx_busy); end
    hold(BIT_CLKS);
  endtask

  task automatic test_back_to_back();
    push_good(8'h00);
    push_good(8'hFF);
    send_frame(8'h00, 1'b1, BIT_CLKS);
    send_frame(8'hFF, 1'b1, BIT_CLKS);
    wait_drain("back_to_back", 4 * BIT_CLKS);
    n_checks++;
    if (rx_data !== 8'hFF) begin n_fail++; $display("FAIL b2b_rx_data: got %h, required ff", rx_data); end
    hold(BIT_CLKS);
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    d  = 8'h5A;
    rx = 1'b0;
    hold(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      hold(BIT_CLKS);
    end
    rx = d[3];
    hold(BIT_CLKS / 2);
    rst = 1'b0;
    hold(4);
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL abort_rx_busy: got %b, required 0", rx_busy); end
    n_checks++;
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL abort_rx_data: got %h, required 00", rx_data); end
    rx = 1'b1;
    hold(4);
    rst = 1'b1;
    exp_hold = 8'h00;
    hold(BIT_CLKS);
    push_good(8'h81);
    send_frame(8'h81, 1'b1, BIT_CLKS);
    wait_drain("reset_abort", 4 * BIT_CLKS);
    n_checks++;
    if (rx_data !== 8'h81) begin n_fail++; $display("FAIL abort_next_frame: got %h, required 81", rx_data); end
    hold(BIT_CLKS);
  endtask

  task automatic test_skew();
    for (int f = 0; f < 10; f++) begin
      push_good(8'h55);
      send_frame(8'h55, 1'b1, (f < 5) ? 66 : 62);
    end
    wait_drain("skew", 4 * BIT_CLKS);
    n_checks++;
    if (rx_data !== 8'h55) begin n_fail++; $display("FAIL skew_rx_data: got %h, required 55", rx_data); end
    hold(BIT_CLKS);
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_abort();
    test_skew();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one parameter: OVS, default 16, number of baud_tick pulses per bit period; legal values are even and from 8 to 16.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low: the block is held in reset while rst=0.
REQ-004 baud_tick  input  1  one-clk-wide pulse at OVS times the bit rate.
REQ-005 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rx_data  output  8  last correctly framed byte, LSB received first.
REQ-007 rx_done  output  1  one-clk pulse when rx_data has just been updated.
REQ-008 frame_err  output  1  one-clk pulse when the stop bit is sampled low.
REQ-009 rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use, giving 2 clk of latency; no other logic SHALL read rx directly.
REQ-011 States SHALL be IDLE, START, DATA, STOP and WAIT_HIGH, with a 4-bit tick counter and a 3-bit bit counter.
REQ-012 IDLE: when rx_s=0 on a clk edge, the block SHALL enter START and clear the tick counter; the baud_tick value at that edge is irrelevant.
REQ-013 START: the tick counter SHALL increment on each baud_tick; on the (OVS/2)-th tick, rx_s is sampled: if 1 (glitch), the block returns to IDLE with no output pulse; if 0, it clears the tick counter and bit counter and enters DATA.
REQ-014 DATA: on every OVS-th tick, the tick counter clears and rx_s shifts into bit 7 of the shift register (right shift).
REQ-015 DATA: after the 8th sample (bit counter wraps 7->0), the block SHALL enter STOP.
REQ-016 STOP: on the OVS-th tick, rx_s is sampled: if 1, the shift register is copied to rx_data, rx_done is 1 on the next clk only, and the block enters IDLE.
REQ-017 STOP: if the sample is 0, frame_err is 1 for one clk, rx_data is unchanged, rx_done stays 0, and the block enters WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL stay until rx_s=1, then go to IDLE; a held-low line (break) therefore produces exactly one frame_err.
REQ-019 rx_done and frame_err SHALL never be high in the same cycle, and each SHALL be high for exactly one clk per frame.
REQ-020 Between baud_ticks, all counters SHALL hold; transitions in START, DATA and STOP occur only on clk edges where baud_tick=1.
REQ-021 A new start bit arriving the clk after rx_done SHALL be accepted (back-to-back frames with one stop bit).
REQ-022 rx_data SHALL hold its value until the next good frame.
REQ-023 A transition into any illegal state code SHALL go to IDLE on the next clk.

Reset
REQ-024 While rst=0, regardless of clk: state=IDLE, counters=0, shift register=0, rx_data=8'h00, rx_done=0, frame_err=0, rx_busy=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-026 After rst deasserts, the first frame SHALL be received normally.

Verification
REQ-027 Frame 0xA5 (OVS=16, rx ideal): rx_done pulses once ~160 ticks after the start edge, rx_data=8'hA5, frame_err=0, rx_busy returns to 0.
REQ-028 Glitch, rx low for 3 ticks then high: START then IDLE, no rx_done or frame_err pulse, rx_data unchanged.
REQ-029 Frame 0x3C with stop bit forced low, then line held low for 40 ticks: one frame_err pulse, rx_data keeps its previous value, rx_busy=1 until rx returns high.
REQ-030 Back-to-back frames 0x00 then 0xFF with no idle gap: two rx_done pulses, rx_data=8'h00 then 8'hFF.
REQ-031 rst pulled low during the 4th data bit of 0x5A, released, then frame 0x81 sent: no pulse from the aborted frame, and rx_data=8'h81 after the second frame.
REQ-032 Bit-time skew of ±3 % on a 0x55 stream of 10 frames: all 10 received correctly with no frame_err.
